// File: rtl/div_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_seq_if
//  Purpose  : start/done handshake and operand/result bundle for div_seq.
//             The requester owns start/sgn/x/y; the divider owns the rest.
//  Revision : 1.0  initial release
// ============================================================================
interface div_seq_if #(
   parameter int DSZ = 32
);
   logic           start;
   logic           sgn;
   logic [DSZ-1:0] x;
   logic [DSZ-1:0] y;
   logic           busy;
   logic           done;
   logic           dz;
   logic           ovf;
   logic [DSZ-1:0] q;
   logic [DSZ-1:0] r;

   modport master (
      output start, sgn, x, y,
      input  busy, done, dz, ovf, q, r
   );

   modport slave (
      input  start, sgn, x, y,
      output busy, done, dz, ovf, q, r
   );
endinterface
`default_nettype wire

// File: rtl/div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_seq
//  Purpose  : Sequential restoring divider, one quotient bit per clock.
//             Signed (truncating) or unsigned mode, divide-by-zero and
//             MIN/-1 overflow flags, results held until the next operation.
//  Revision : 1.0  initial release
// ============================================================================
module div_seq #(
   parameter int DSZ = 32
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   div_seq_if.slave   bus
);

   localparam int             CW          = $clog2(DSZ);
   localparam logic [CW-1:0]  c_CNT_INIT  = CW'(DSZ - 1);
   localparam logic [DSZ-1:0] c_MIN       = {1'b1, {(DSZ-1){1'b0}}};
   localparam logic [DSZ-1:0] c_ONES      = {DSZ{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           w_load;
   logic           w_step;
   logic           w_fix;

   // operation context captured at start
   logic           r_xs;
   logic           r_ys;
   logic           r_dzp;
   logic           r_ovfp;
   logic [DSZ-1:0] r_ymag;
   logic [CW-1:0]  r_cnt;

   // iteration registers: quo shifts out dividend bits, shifts in quotient bits
   logic [DSZ-1:0] r_rem;
   logic [DSZ-1:0] r_quo;

   // registered outputs
   logic           r_busy;
   logic           r_done;
   logic           r_dz;
   logic           r_ovf;
   logic [DSZ-1:0] r_q;
   logic [DSZ-1:0] r_r;

   // operand sign/magnitude decode
   logic           w_xs;
   logic           w_ys;
   logic [DSZ-1:0] w_xmag;
   logic [DSZ-1:0] w_ymag;

   // one restoring step
   logic [DSZ:0]   w_sh;
   logic           w_ge;
   logic [DSZ-1:0] w_rem_nxt;

   assign w_xs   = bus.sgn & bus.x[DSZ-1];
   assign w_ys   = bus.sgn & bus.y[DSZ-1];
   // |MIN| = 2^(DSZ-1) is representable as an unsigned DSZ-bit value
   assign w_xmag = w_xs ? -bus.x : bus.x;
   assign w_ymag = w_ys ? -bus.y : bus.y;

   // The shifted partial remainder needs DSZ+1 bits; after a conditional
   // subtract it is always below |y|, so DSZ bits suffice to store it and
   // the DSZ-bit modular difference is exact.
   assign w_sh      = {r_rem, r_quo[DSZ-1]};
   assign w_ge      = (w_sh >= {1'b0, r_ymag});
   assign w_rem_nxt = w_ge ? (w_sh[DSZ-1:0] - r_ymag) : w_sh[DSZ-1:0];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state decode and per-state datapath strobes
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_fix       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = (bus.y == '0) ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            w_step = 1'b1;
            if (r_cnt == '0) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            w_fix       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // operand capture and shift-subtract iteration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xs   <= 1'b0;
         r_ys   <= 1'b0;
         r_dzp  <= 1'b0;
         r_ovfp <= 1'b0;
         r_ymag <= '0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
      end else if (w_load) begin
         r_xs   <= w_xs;
         r_ys   <= w_ys;
         r_dzp  <= (bus.y == '0);
         r_ovfp <= bus.sgn & (bus.x == c_MIN) & (bus.y == c_ONES);
         r_ymag <= w_ymag;
         r_cnt  <= c_CNT_INIT;
         r_rem  <= '0;
         // a zero divisor skips CALC, so quo can carry the raw dividend
         // through to FIX where it becomes the remainder
         r_quo  <= (bus.y == '0) ? bus.x : w_xmag;
      end else if (w_step) begin
         r_cnt  <= r_cnt - CW'(1);
         r_rem  <= w_rem_nxt;
         r_quo  <= {r_quo[DSZ-2:0], w_ge};
      end
   end

   // result registration, sign fix-up and handshake flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         r_ovf  <= 1'b0;
         r_q    <= '0;
         r_r    <= '0;
      end else begin
         r_done <= w_fix;
         if (w_load) begin
            r_busy <= 1'b1;
         end else if (w_fix) begin
            r_busy <= 1'b0;
         end
         if (w_fix) begin
            if (r_dzp) begin
               r_q   <= c_ONES;
               r_r   <= r_quo;
               r_dz  <= 1'b1;
               r_ovf <= 1'b0;
            end else begin
               // truncating division: remainder follows the dividend sign;
               // MIN/-1 wraps naturally to q=MIN, r=0
               r_q   <= (r_xs ^ r_ys) ? -r_quo : r_quo;
               r_r   <= r_xs ? -r_rem : r_rem;
               r_dz  <= 1'b0;
               r_ovf <= r_ovfp;
            end
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.dz   = r_dz;
   assign bus.ovf  = r_ovf;
   assign bus.q    = r_q;
   assign bus.r    = r_r;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq
//  Purpose  : Self-checking bench for div_seq, DSZ=32 and DSZ=8 instances,
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   div_seq_if #(.DSZ(32)) b32 ();
   div_seq_if #(.DSZ(8))  b8  ();

   div_seq #(.DSZ(32)) dut   (.clk(clk), .rst_n(rst_n), .bus(b32));
   div_seq #(.DSZ(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // reference: plain truncating integer division at width n
   function automatic void model(input int n, input bit s, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] eq,
                                 output logic [63:0] er, output logic edz,
                                 output logic eovf);
      logic [63:0] m;
      longint      sa, sb;
      m    = (64'd1 << n) - 64'd1;
      edz  = (b == 64'd0);
      eovf = 1'b0;
      if (b == 64'd0) begin
         eq = m;
         er = a;
      end else if (!s) begin
         eq = a / b;
         er = a % b;
      end else begin
         sa   = a[n-1] ? longint'(a) - (longint'(1) << n) : longint'(a);
         sb   = b[n-1] ? longint'(b) - (longint'(1) << n) : longint'(b);
         eq   = 64'(sa / sb) & m;
         er   = 64'(sa % sb) & m;
         eovf = (sa == -(longint'(1) << (n - 1))) && (sb == -1);
      end
   endfunction

   function automatic logic [63:0] pick(input int n);
      logic [63:0] m;
      m = (64'd1 << n) - 64'd1;
      case ($urandom_range(0, 6))
         0:       pick = 64'd0;
         1:       pick = 64'd1 << (n - 1);
         2:       pick = m;
         3:       pick = 64'd1;
         default: pick = {32'($urandom), 32'($urandom)} & m;
      endcase
   endfunction

   task automatic drive(input bit w8, input bit st, input bit s,
                        input logic [63:0] a, input logic [63:0] b);
      if (w8) begin
         b8.start = st;  b8.sgn = s;  b8.x = a[7:0];  b8.y = b[7:0];
      end else begin
         b32.start = st; b32.sgn = s; b32.x = a[31:0]; b32.y = b[31:0];
      end
   endtask

   task automatic snap(input bit w8, output logic bz, output logic dn, output logic dzo,
                       output logic ov, output logic [63:0] qo, output logic [63:0] ro);
      if (w8) begin
         bz = b8.busy;  dn = b8.done;  dzo = b8.dz;  ov = b8.ovf;
         qo = {56'd0, b8.q};  ro = {56'd0, b8.r};
      end else begin
         bz = b32.busy; dn = b32.done; dzo = b32.dz; ov = b32.ovf;
         qo = {32'd0, b32.q}; ro = {32'd0, b32.r};
      end
   endtask

   // one full operation; now=1 issues start in the current (done) cycle,
   // noise=1 pulses start with junk operands at edges 5 and 20
   task automatic run(input string nm, input bit w8, input bit s, input logic [63:0] a,
                      input logic [63:0] b, input bit now, input bit noise);
      logic [63:0] eq, er, qo, ro;
      logic        edz, eovf, bz, dn, dzo, ov;
      int          w, lat, n, busy_bad;
      w   = w8 ? 8 : 32;
      model(w, s, a, b, eq, er, edz, eovf);
      lat = (b == 64'd0) ? 1 : w + 1;
      if (!now) @(negedge clk);
      drive(w8, 1'b1, s, a, b);
      @(posedge clk); #1;
      drive(w8, 1'b0, s, a, b);
      n = 0;
      busy_bad = 0;
      snap(w8, bz, dn, dzo, ov, qo, ro);
      while (!dn && n < 100) begin
         if (!bz) busy_bad++;
         if (noise && (n == 4 || n == 19))
            drive(w8, 1'($urandom_range(0, 1)), 1'b1, pick(w), pick(w));
         else
            drive(w8, 1'b0, s, a, b);
         @(posedge clk); #1;
         n++;
         snap(w8, bz, dn, dzo, ov, qo, ro);
      end
      chk({nm, ".latency"}, 64'(n), 64'(lat));
      chk({nm, ".busy_run"}, 64'(busy_bad), 64'd0);
      chk({nm, ".busy_done"}, {63'd0, bz}, 64'd0);
      chk({nm, ".q"}, qo, eq);
      chk({nm, ".r"}, ro, er);
      chk({nm, ".dz"}, {63'd0, dzo}, {63'd0, edz});
      chk({nm, ".ovf"}, {63'd0, ov}, {63'd0, eovf});
   endtask

   initial begin
      logic [63:0] qo, ro, q_keep;
      logic        bz, dn, dzo, ov;
      bit          s;

      drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // reset state
      snap(1'b0, bz, dn, dzo, ov, qo, ro);
      chk("rst.busy", {63'd0, bz}, 64'd0);
      chk("rst.done", {63'd0, dn}, 64'd0);
      chk("rst.flags", {62'd0, dzo, ov}, 64'd0);
      chk("rst.q", qo, 64'd0);
      chk("rst.r", ro, 64'd0);

      // directed, DSZ=32
      run("u100_7", 1'b0, 1'b0, 64'd100, 64'd7, 1'b0, 1'b0);
      chk("u100_7.q_abs", {32'd0, b32.q}, 64'd14);
      chk("u100_7.r_abs", {32'd0, b32.r}, 64'd2);
      run("sm7_2", 1'b0, 1'b1, 64'hFFFF_FFF9, 64'd2, 1'b0, 1'b0);
      chk("sm7_2.q_abs", {32'd0, b32.q}, 64'hFFFF_FFFD);
      run("s7_m2_b2b", 1'b0, 1'b1, 64'd7, 64'hFFFF_FFFE, 1'b1, 1'b0);
      chk("s7_m2.r_abs", {32'd0, b32.r}, 64'd1);
      run("dz5", 1'b0, 1'b1, 64'd5, 64'd0, 1'b0, 1'b0);
      run("uff_1", 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
      run("s_ovf", 1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0);
      chk("s_ovf.flag_abs", {63'd0, b32.ovf}, 64'd1);
      run("u_min_ff", 1'b0, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0);
      run("noise", 1'b0, 1'b0, 64'd123456789, 64'd321, 1'b0, 1'b1);

      // done is a single pulse and results hold afterwards
      q_keep = {32'd0, b32.q};
      @(posedge clk); #1;
      chk("done_pulse", {63'd0, b32.done}, 64'd0);
      repeat (3) @(posedge clk); #1;
      chk("hold.q", {32'd0, b32.q}, q_keep);

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 64'd999, 64'd5);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 64'd999, 64'd5);
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      snap(1'b0, bz, dn, dzo, ov, qo, ro);
      chk("midrst.busy", {63'd0, bz}, 64'd0);
      chk("midrst.done", {63'd0, dn}, 64'd0);
      chk("midrst.q", qo, 64'd0);
      chk("midrst.r", ro, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst.no_done", {63'd0, b32.done}, 64'd0);
      chk("midrst.still_0", {32'd0, b32.q}, 64'd0);
      run("after_rst", 1'b0, 1'b0, 64'd1000, 64'd33, 1'b0, 1'b0);

      // directed, DSZ=8
      run("w8_200_3", 1'b1, 1'b0, 64'd200, 64'd3, 1'b0, 1'b0);
      chk("w8_200_3.q_abs", {56'd0, b8.q}, 64'd66);
      run("w8_m56_3", 1'b1, 1'b1, 64'hC8, 64'd3, 1'b0, 1'b0);
      chk("w8_m56_3.q_abs", {56'd0, b8.q}, 64'hEE);
      chk("w8_m56_3.r_abs", {56'd0, b8.r}, 64'hFE);
      run("w8_ovf", 1'b1, 1'b1, 64'h80, 64'hFF, 1'b0, 1'b0);

      // randomized against the model
      for (int k = 0; k < 12; k++) begin
         s = 1'($urandom_range(0, 1));
         run("rnd32", 1'b0, s, pick(32), pick(32), 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int k = 0; k < 20; k++) begin
         s = 1'($urandom_range(0, 1));
         run("rnd8", 1'b1, s, pick(8), pick(8), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
